// File: rtl/cpu_bus_ctrl.sv
// MCS8 bus-cycle controller: drives the multiplexed data bus from the T-state/cycle code,
// latches instruction bytes, mirrors the state code and counts wait states.
module cpu_bus_ctrl #(
  parameter int WAIT_LIMIT = 16,
  parameter int WCNT_W     = 8
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              STB_I,
  input  logic [2:0]        STATE_I,
  input  logic [1:0]        CYCLE_I,
  input  logic [1:0]        CYC_TYPE_I,
  input  logic [13:0]       ADDR_I,
  input  logic [7:0]        DATA_I,
  input  logic [7:0]        D_I,
  output logic [7:0]        D_O,
  output logic              D_OE_O,
  output logic [2:0]        S_O,
  output logic [7:0]        IR_O,
  output logic              IR_LD_O,
  output logic [7:0]        B2_O,
  output logic [7:0]        B3_O,
  output logic              INTA_O,
  output logic [WCNT_W-1:0] WAIT_CNT_O,
  output logic              WAIT_TMO_O,
  output logic              ERR_O
);

  typedef enum logic [2:0] {
    ST_WAIT = 3'b000, ST_T3  = 3'b001, ST_T1  = 3'b010, ST_STOP = 3'b011,
    ST_T2   = 3'b100, ST_T5  = 3'b101, ST_T1I = 3'b110, ST_T4   = 3'b111
  } state_e;

  localparam logic [1:0] CYC_C1  = 2'b00;
  localparam logic [1:0] CYC_C2  = 2'b01;
  localparam logic [1:0] CYC_C3  = 2'b10;
  localparam logic [1:0] CYC_ILL = 2'b11;
  localparam logic [1:0] TY_PCI  = 2'b00;
  localparam logic [1:0] TY_PCC  = 2'b01;
  localparam logic [1:0] TY_PCW  = 2'b11;
  localparam logic [WCNT_W-1:0] WCNT_ONE = {{(WCNT_W-1){1'b0}}, 1'b1};

  state_e            st_q, st_d, new_st;
  logic [1:0]        cyc_q, cyc_d, type_q, type_d, new_type;
  logic [7:0]        d_o_q, d_o_d, ir_q, ir_d, b2_q, b2_d, b3_q, b3_d;
  logic              d_oe_q, d_oe_d, ir_ld_q, ir_ld_d, inta_q, inta_d;
  logic              tmo_q, tmo_d, err_q, err_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  always_comb begin
    st_d     = st_q;
    cyc_d    = cyc_q;
    type_d   = type_q;
    d_o_d    = d_o_q;
    d_oe_d   = d_oe_q;
    ir_d     = ir_q;
    ir_ld_d  = 1'b0;
    b2_d     = b2_q;
    b3_d     = b3_q;
    inta_d   = inta_q;
    wcnt_d   = wcnt_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    new_st   = state_e'(STATE_I);
    new_type = (CYCLE_I == CYC_C1) ? TY_PCI : CYC_TYPE_I;

    if (STB_I) begin
      st_d   = new_st;
      cyc_d  = CYCLE_I;
      type_d = new_type;

      // End of a read T3: capture uses the state being left, not the one entered.
      if (st_q == ST_T3 && !d_oe_q && cyc_q != CYC_ILL) begin
        case (cyc_q)
          CYC_C1: begin
            ir_d    = D_I;
            ir_ld_d = 1'b1;
            inta_d  = 1'b0;
          end
          CYC_C2:  b2_d = D_I;
          CYC_C3:  b3_d = D_I;
          default: ;
        endcase
      end

      tmo_d = 1'b0;
      case (new_st)
        ST_T1, ST_T1I: begin
          d_o_d  = ADDR_I[7:0];
          d_oe_d = 1'b1;
        end
        ST_T2: begin
          d_o_d  = {new_type, ADDR_I[13:8]};
          d_oe_d = 1'b1;
          wcnt_d = '0;
        end
        ST_WAIT: begin
          d_oe_d = 1'b0;
          if (wcnt_q != '1) wcnt_d = wcnt_q + WCNT_ONE;
          tmo_d = (32'(wcnt_d) >= WAIT_LIMIT);
        end
        ST_T3: begin
          if (new_type == TY_PCW || (new_type == TY_PCC && CYCLE_I == CYC_C2)) begin
            d_o_d  = DATA_I;
            d_oe_d = 1'b1;
          end else begin
            d_oe_d = 1'b0;
          end
        end
        default: d_oe_d = 1'b0;
      endcase

      if (new_st == ST_T1I) inta_d = 1'b1;

      if (CYCLE_I == CYC_ILL) begin
        err_d  = 1'b1;
        d_oe_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      st_q    <= ST_STOP;
      cyc_q   <= CYC_C1;
      type_q  <= TY_PCI;
      d_o_q   <= '0;
      d_oe_q  <= 1'b0;
      ir_q    <= '0;
      ir_ld_q <= 1'b0;
      b2_q    <= '0;
      b3_q    <= '0;
      inta_q  <= 1'b0;
      wcnt_q  <= '0;
      tmo_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      cyc_q   <= cyc_d;
      type_q  <= type_d;
      d_o_q   <= d_o_d;
      d_oe_q  <= d_oe_d;
      ir_q    <= ir_d;
      ir_ld_q <= ir_ld_d;
      b2_q    <= b2_d;
      b3_q    <= b3_d;
      inta_q  <= inta_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign D_O        = d_o_q;
  assign D_OE_O     = d_oe_q;
  assign S_O        = st_q;
  assign IR_O       = ir_q;
  assign IR_LD_O    = ir_ld_q;
  assign B2_O       = b2_q;
  assign B3_O       = b3_q;
  assign INTA_O     = inta_q;
  assign WAIT_CNT_O = wcnt_q;
  assign WAIT_TMO_O = tmo_q;
  assign ERR_O      = err_q;

endmodule
